// File: rtl/pc_predict_pkg.sv
// Shared definitions for the fetch-stage PC predictor: counter encodings and helpers.
package pc_predict_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CtrSnt   = 2'b00;
  localparam ctr_t CtrWnt   = 2'b01;
  localparam ctr_t CtrWt    = 2'b10;
  localparam ctr_t CtrSt    = 2'b11;
  localparam ctr_t CtrAlloc = CtrWt;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
module bp_btb
  import pc_predict_pkg::*;
#(
  parameter int unsigned BTB_DEPTH = 16,
  parameter int unsigned WIDTH     = 32
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic [WIDTH-1:2] lookup_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:2] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int unsigned IDXW = clog2(BTB_DEPTH);
  localparam int unsigned TAGW = WIDTH - IDXW - 2;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAGW-1:0]      tag_q [BTB_DEPTH];
  ctr_t                 ctr_q [BTB_DEPTH];
  logic [WIDTH-1:0]     tgt_q [BTB_DEPTH];

  logic [IDXW-1:0] l_idx, u_idx;
  logic [TAGW-1:0] l_tag, u_tag;
  logic            l_hit, u_hit;
  ctr_t            ctr_upd;

  assign l_idx = lookup_pc[IDXW+1:2];
  assign l_tag = lookup_pc[WIDTH-1:IDXW+2];
  assign u_idx = upd_pc[IDXW+1:2];
  assign u_tag = upd_pc[WIDTH-1:IDXW+2];

  // Lookup reads pre-update contents; an update at the same index shows next cycle.
  always_comb begin
    l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = l_hit && ctr_q[l_idx][1];
    pred_target = l_hit ? tgt_q[l_idx] : '0;
  end

  always_comb begin
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    ctr_upd = ctr_q[u_idx];
    if (upd_taken) begin
      if (ctr_q[u_idx] != CtrSt) ctr_upd = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != CtrSnt) ctr_upd = ctr_q[u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      valid_q <= '0;
    end else if (upd_valid && !u_hit && upd_taken) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_upd;
        if (upd_taken) tgt_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_q[u_idx] <= u_tag;
        ctr_q[u_idx] <= CtrAlloc;
        tgt_q[u_idx] <= upd_target;
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register with halt/stall hold, BTB-directed prediction and EX redirect.
module pc_predict_unit
  import pc_predict_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      BTB_DEPTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      INC       = 4
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             contin,
  input  logic             sys,
  input  logic             notequal,
  input  logic             bubble,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  output logic [WIDTH-1:0] PC,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  output logic             run,
  output logic [WIDTH-1:0] redirect_cnt
);

  localparam logic [WIDTH-1:0] IncW = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  bp_btb #(
    .BTB_DEPTH(BTB_DEPTH),
    .WIDTH    (WIDTH)
  ) u_btb (
    .clk        (clk),
    .RST_n      (RST_n),
    .lookup_pc  (pc_q[WIDTH-1:2]),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc[WIDTH-1:2]),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  assign run = contin | ~(sys & notequal);

  // A redirect from EX wins over stall and halt so a mispredict is never lost.
  always_comb begin
    pc_d = pc_q + IncW;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!run || bubble) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redirect && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign PC           = pc_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Parametrised fetch-stage PC unit for the pipelined MIPS core; successor to the fixed 32-bit PC register.
- Keeps the run/halt rule (contin, sys, notequal) and the stall/bubble hold.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch follows predicted-taken branches.
- Accepts a redirect from EX on mispredict, and counts redirects.
- Sits between the IF-stage instruction memory address and the IF/ID register; pred_taken/pred_target travel down the pipe for resolution in EX.

Parameters:
WIDTH, 32, PC and target width in bits (>= IDXW+3).
BTB_DEPTH, 16, number of BTB entries; power of two, >= 2.
RESET_PC, 0, PC value after reset.
INC, 4, sequential PC increment.

Ports:
clk  in  1  clock, rising-edge.
RST_n  in  1  asynchronous active-low reset.
contin  in  1  resume after syscall halt.
sys  in  1  syscall in decode.
notequal  in  1  syscall halt condition qualifier.
bubble  in  1  load-use stall; hold PC.
redirect  in  1  EX mispredict; load redirect_pc.
redirect_pc  in  WIDTH  correct next PC from EX.
upd_valid  in  1  EX resolved a branch/jump this cycle.
upd_pc  in  WIDTH  PC of the resolved instruction.
upd_taken  in  1  actual outcome.
upd_target  in  WIDTH  actual target.
PC  out  WIDTH  current fetch PC (registered).
pred_taken  out  1  BTB hit and counter[1]==1 for the current PC.
pred_target  out  WIDTH  BTB target for the current PC; 0 on miss.
run  out  1  contin | ~(sys & notequal).
redirect_cnt  out  WIDTH  saturating count of accepted redirects.

Behaviour:
- IDXW = log2(BTB_DEPTH).
  - Index = PC[IDXW+1:2].
  - Tag = PC[WIDTH-1:IDXW+2].
  - Entry fields: valid, tag, 2-bit counter, target.
- Reset (RST_n=0, async):
  - PC=RESET_PC; redirect_cnt=0; all valid=0.
  - pred_taken=0, pred_target=0 (these follow combinationally).
  - Counters and targets are don't-care.
  - A reset asserted mid-update discards that update.
- Lookup is combinational from the registered PC. pred_* are valid in the same cycle as PC.
- Next-PC priority, evaluated each rising edge:
  1. redirect: PC<=redirect_pc. Overrides bubble and halt. redirect_cnt increments unless it is all-ones.
  2. ~run or bubble: hold PC.
  3. pred_taken: PC<=pred_target.
  4. Otherwise: PC<=PC+INC, modulo 2^WIDTH. Wrap from all-ones region to low addresses is silent.
- BTB update, on upd_valid, independent of stall/halt/redirect:
  - Hit (valid and tag match at upd_pc index):
    - Counter saturating +1 if upd_taken, -1 if not (00..11, no wrap).
    - Target <= upd_target when upd_taken.
  - Miss and upd_taken: allocate (replace). valid=1, tag from upd_pc, counter=2'b10, target=upd_target.
  - Miss and not taken: no change.
- A same-cycle lookup and update to the same index returns old contents (no bypass). The new state is visible next cycle.
- run is purely combinational. PC holds as long as run=0. contin=1 releases in the same cycle.
- Single-cycle latency: a redirect or update at edge N is reflected in PC/pred_* after edge N.

Decomposition:
- Package pc_predict_pkg:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - Allocation counter value WT.
  - Function clog2.
- Sub-module bp_btb (BTB_DEPTH, WIDTH):
  - Storage plus combinational lookup and update logic.
  - Async-clears valid bits.
- The top level holds the PC register, the next-PC mux, run and redirect_cnt.

Test Plan:
- Reset then 4 free cycles, no updates -> PC 0,4,8,12,16; pred_taken=0 throughout; redirect_cnt=0.
- upd_valid, upd_pc=0x10, taken, target 0x40 -> next time PC=0x10: pred_taken=1, pred_target=0x40, following PC=0x40.
- Two not-taken updates to 0x10 (counter 10->01->00) -> at PC=0x10 pred_taken=0, next PC=0x14; a third not-taken update keeps the counter at 00.
- redirect=1, redirect_pc=0x200, with bubble=1 and sys=notequal=1 -> PC=0x200, redirect_cnt=1.
- sys=notequal=1, contin=0 for 3 cycles -> run=0, PC held; contin=1 -> run=1, PC advances by 4 next edge.
- RST_n low mid-cycle while upd_valid -> PC=RESET_PC immediately; after release a lookup of that entry misses; PC near 2^WIDTH-4 + INC wraps to 0.
